vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares the single memory port B of the GeneralCPU data memory between two requesters:
  - the VGA display fetch path (real-time, high priority);
  - an auxiliary requester, e.g. a sprite/clear DMA or debug writer.
- Sits between vgaDisplay/aux logic and the CPU's port-B pins (memData/addr/writeEnable/memOutput).
- Issues at most one access per cycle and routes read data back to whichever requester issued it.
- Bounds auxiliary starvation with a wait counter, overridable by a VGA "urgent" hint.

Parameters:
- ADDR_WIDTH, 16, width of port-B address.
- DATA_WIDTH, 16, width of port-B data.
- RD_LATENCY, 1, memory cycles from sampled address to valid mem_rdata (>=1).
- MAX_WAIT, 8, cycles aux may be denied before forced grant (>=1).

Ports:
- clk  in  1  50MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request; held with vga_addr until granted.
- vga_addr  in  ADDR_WIDTH  VGA read address.
- vga_urgent  in  1  VGA FIFO low; blocks forced aux grant.
- vga_gnt  out  1  transfer accepted at this edge (combinational).
- vga_rdata  out  DATA_WIDTH  read data returned to VGA.
- vga_rvalid  out  1  vga_rdata valid this cycle.
- aux_req  in  1  aux request; held with aux_we/addr/wdata until granted.
- aux_we  in  1  1 = write, 0 = read.
- aux_addr  in  ADDR_WIDTH  aux address.
- aux_wdata  in  DATA_WIDTH  aux write data.
- aux_gnt  out  1  transfer accepted at this edge (combinational).
- aux_rdata  out  DATA_WIDTH  read data returned to aux.
- aux_rvalid  out  1  aux_rdata valid this cycle.
- aux_forced  out  1  one-cycle pulse: aux was granted via starvation override.
- mem_addr  out  ADDR_WIDTH  to CPU port-B addr.
- mem_we  out  1  to CPU port-B writeEnable.
- mem_wdata  out  DATA_WIDTH  to CPU port-B memData.
- mem_rdata  in  DATA_WIDTH  from CPU port-B memOutput.

Behaviour:
- Transfer occurs at a rising edge where req && gnt; the requester may change its inputs after that edge.
- Grant logic:
  - force = aux_req && wait_cnt==MAX_WAIT && !vga_urgent.
  - vga_gnt = vga_req && !force.
  - aux_gnt = aux_req && (!vga_req || force).
  - Both grants are forced 0 while reset is low; never both high.
- wait_cnt:
  - +1 on each edge with aux_req && !aux_gnt, saturating at MAX_WAIT.
  - Cleared on an aux transfer or when aux_req is low.
- aux_forced: registered; 1 for the cycle after a transfer granted via force, else 0.
- Command register, updated on each transfer edge:
  - mem_addr <= granted addr.
  - mem_we <= aux_we for aux transfers, 0 for VGA transfers.
  - mem_wdata <= aux_wdata for aux transfers.
- No transfer at an edge: mem_we <= 0; mem_addr and mem_wdata hold their last values.
- Read return:
  - A tag (NONE/VGA/AUX) enters a RD_LATENCY+1 deep pipe on each edge. Writes and idle cycles enter NONE.
  - Read data arrives RD_LATENCY+1 cycles after the transfer edge.
  - *_rdata = mem_rdata combinationally; *_rvalid = pipe tail tag match.
  - Back-to-back reads return in issue order, one per cycle.
- Read-after-write to the same address on consecutive transfers returns the new data (memory port ordering; no bypass).
- Reset (async, active-low) clears:
  - mem_addr=0, mem_we=0, mem_wdata=0;
  - tag pipe all NONE, so vga_rvalid=aux_rvalid=0;
  - wait_cnt=0, aux_forced=0.
- Reset mid-operation: in-flight reads are dropped with no rvalid; writes already presented to memory are not retracted.
- vga_urgent high holds off force indefinitely; wait_cnt stays saturated and force fires on the first edge where urgent drops with aux_req still high.

Decomposition:
- Package capman_mem_pkg holds:
  - default ADDR_WIDTH/DATA_WIDTH;
  - the tag enum TAG_NONE/TAG_VGA/TAG_AUX (2 bits);
  - the MAX_WAIT default.
- One sub-module, rd_tag_pipe: parameterised-depth shift register of tags with async active-low clear.

Test Plan:
- Reset: hold reset low with vga_req=1 -> gnts 0, mem_we 0, rvalids 0; release reset -> vga_gnt=1 the same cycle.
- VGA-only streaming: vga_req held with addr 0x0100..0x0103 -> four transfers on consecutive edges; vga_rvalid high 2 cycles after each (RD_LATENCY=1) with matching preloaded data.
- Aux write then read:
  - aux write 0x1234 to 0x0050, then aux read 0x0050, VGA idle;
  - expect mem_we=1 for exactly one cycle, then aux_rvalid with 0x1234, vga_rvalid never asserted.
- Starvation, no urgency: vga_req held high, aux read pending, vga_urgent=0 -> aux_gnt on the 9th edge (MAX_WAIT=8), aux_forced pulse next cycle, VGA resumes after.
- Urgency hold-off: same setup with vga_urgent=1 for 20 cycles -> aux never granted and wait_cnt stays at 8; urgent drop -> aux granted at that edge.
- Mid-flight reset: VGA read granted, reset asserted 1 cycle later -> no vga_rvalid ever for that read; outputs at reset values.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package   : capman_mem_pkg
// Purpose   : Shared defaults and the read-return tag type for the VRAM
//             port-B arbiter and its read-tag pipeline.
// Contents  : DEF_ADDR_WIDTH, DEF_DATA_WIDTH, DEF_MAX_WAIT, rd_tag_e
// Revision  : 1.0 - initial release
// ============================================================================
package capman_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_WAIT   = 8;

  // Identifies which requester owns a read that is in flight.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_AUX  = 2'd2
  } rd_tag_e;

endpackage
`default_nettype wire

// File: rtl/vram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : vram_port_arbiter_if
// Purpose   : Bundles the VGA requester, aux requester and CPU port-B signals
//             that pass through the VRAM port arbiter.
// Modports  : slave  - arbiter side (takes requests, drives port B)
//             master - environment side (requesters + memory)
// Revision  : 1.0 - initial release
// ============================================================================
interface vram_port_arbiter_if
  import capman_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  // VGA display fetch path
  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_urgent;
  logic                  vga_gnt;
  logic [DATA_WIDTH-1:0] vga_rdata;
  logic                  vga_rvalid;

  // Auxiliary requester
  logic                  aux_req;
  logic                  aux_we;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic [DATA_WIDTH-1:0] aux_wdata;
  logic                  aux_gnt;
  logic [DATA_WIDTH-1:0] aux_rdata;
  logic                  aux_rvalid;
  logic                  aux_forced;

  // CPU data memory port B
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, vga_urgent,
    output vga_gnt, vga_rdata, vga_rvalid,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rdata, aux_rvalid, aux_forced,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr, vga_urgent,
    input  vga_gnt, vga_rdata, vga_rvalid,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rdata, aux_rvalid, aux_forced,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/vram_port_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module    : rd_tag_pipe
// Purpose   : Fixed-depth shift register of read-owner tags. The tail tells
//             the arbiter which requester owns mem_rdata in this cycle.
// Ports     : clk     - system clock
//             reset   - asynchronous active-low clear (all stages TAG_NONE)
//             tag_in  - tag for the access issued at this edge
//             tag_out - tag of the access whose data is on mem_rdata now
// Revision  : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
  import capman_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_e tag_in,
  output rd_tag_e tag_out
);

  rd_tag_e stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : vram_port_arbiter
// Purpose   : Shares CPU data-memory port B between the VGA fetch path (high
//             priority) and an auxiliary requester. One access per cycle;
//             read data is steered back to whichever requester issued it.
//             Aux starvation is bounded by a wait counter, which the VGA
//             urgent hint can hold off.
// Ports     : clk   - 50 MHz system clock
//             reset - asynchronous active-low reset
//             bus   - vram_port_arbiter_if.slave (VGA, aux and port-B signals)
// Revision  : 1.0 - initial release
// ============================================================================
module vram_port_arbiter
  import capman_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  vram_port_arbiter_if.slave    bus
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]     wait_cnt;
  logic                  force_aux;
  logic                  vga_gnt;
  logic                  aux_gnt;
  logic                  aux_forced;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  rd_tag_e               tag_in;
  rd_tag_e               tag_tail;

  // ---------------- Grant logic (combinational) ----------------
  // Grants are qualified with reset so nothing is accepted while the
  // block is held in reset.
  assign force_aux = bus.aux_req && (wait_cnt == WAIT_SAT) && !bus.vga_urgent;
  assign vga_gnt   = reset && bus.vga_req && !force_aux;
  assign aux_gnt   = reset && bus.aux_req && (!bus.vga_req || force_aux);

  // ---------------- Starvation counter ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      aux_forced <= 1'b0;
    end else begin
      if (bus.aux_req && !aux_gnt) begin
        if (wait_cnt != WAIT_SAT) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      // force_aux implies aux_req, hence aux_gnt.
      aux_forced <= force_aux;
    end
  end

  // ---------------- Port-B command register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (vga_gnt) begin
      mem_addr  <= bus.vga_addr;
      mem_we    <= 1'b0;
    end else if (aux_gnt) begin
      mem_addr  <= bus.aux_addr;
      mem_we    <= bus.aux_we;
      mem_wdata <= bus.aux_wdata;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // ---------------- Read-return tagging ----------------
  // Writes and idle cycles push TAG_NONE so the pipe advances every edge
  // and the tail always lines up with mem_rdata.
  always_comb begin
    tag_in = TAG_NONE;
    if (vga_gnt) begin
      tag_in = TAG_VGA;
    end else if (aux_gnt && !bus.aux_we) begin
      tag_in = TAG_AUX;
    end
  end

  rd_tag_pipe #(
    .DEPTH   (RD_LATENCY + 1)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  // ---------------- Outputs ----------------
  assign bus.vga_gnt    = vga_gnt;
  assign bus.aux_gnt    = aux_gnt;
  assign bus.aux_forced = aux_forced;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.vga_rdata  = bus.mem_rdata;
  assign bus.aux_rdata  = bus.mem_rdata;
  assign bus.vga_rvalid = (tag_tail == TAG_VGA);
  assign bus.aux_rvalid = (tag_tail == TAG_AUX);

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_vram_port_arbiter
// Purpose   : Self-checking bench for vram_port_arbiter: directed scenarios
//             followed by randomized traffic, all checked against a
//             behavioural model of the arbitration and memory ordering rules.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_vram_port_arbiter;
  import capman_mem_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  vram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (1),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Preloaded memory content pattern.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // ---------------- Port-B memory (RD_LATENCY = 1, synchronous) ----------------
  logic [DW-1:0] ram [logic [AW-1:0]];
  logic [DW-1:0] ram_rd;
  always @(posedge clk) begin
    ram_rd = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : init_val(bus.mem_addr);
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= ram_rd;
  end

  // ---------------- Reference model state ----------------
  logic [DW-1:0] gold [logic [AW-1:0]];
  int            exp_who  [int];   // 1 = VGA, 2 = AUX, keyed by cycle
  logic [DW-1:0] exp_data [int];
  int            wcnt;
  bit            e_forced;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  int            cyc;
  bit            last_vg, last_ag;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // One clock cycle: called at the negedge with inputs already driven.
  task automatic tick();
    bit f, vg, ag;
    int ev;
    #1;
    if (!reset) begin
      wcnt = 0; e_forced = 0; e_addr = '0; e_we = 0; e_wdata = '0;
      exp_who.delete(); exp_data.delete();
    end
    f  = reset && bus.aux_req && (wcnt == MAXW) && !bus.vga_urgent;
    vg = reset && bus.vga_req && !f;
    ag = reset && bus.aux_req && (!bus.vga_req || f);
    check("vga_gnt",    bus.vga_gnt,    vg);
    check("aux_gnt",    bus.aux_gnt,    ag);
    check("mem_we",     bus.mem_we,     e_we);
    check("mem_addr",   bus.mem_addr,   e_addr);
    check("mem_wdata",  bus.mem_wdata,  e_wdata);
    check("aux_forced", bus.aux_forced, e_forced);
    ev = exp_who.exists(cyc) ? exp_who[cyc] : 0;
    check("vga_rvalid", bus.vga_rvalid, ev == 1);
    check("aux_rvalid", bus.aux_rvalid, ev == 2);
    if (ev == 1) check("vga_rdata", bus.vga_rdata, exp_data[cyc]);
    if (ev == 2) check("aux_rdata", bus.aux_rdata, exp_data[cyc]);
    last_vg = vg;
    last_ag = ag;
    @(posedge clk);
    if (reset) begin
      if (vg) begin
        e_addr = bus.vga_addr; e_we = 0;
        exp_who[cyc+2] = 1; exp_data[cyc+2] = gold_rd(bus.vga_addr);
      end else if (ag) begin
        e_addr = bus.aux_addr; e_we = bus.aux_we; e_wdata = bus.aux_wdata;
        if (bus.aux_we) gold[bus.aux_addr] = bus.aux_wdata;
        else begin exp_who[cyc+2] = 2; exp_data[cyc+2] = gold_rd(bus.aux_addr); end
      end else begin
        e_we = 0;
      end
      e_forced = f;
      if (bus.aux_req && !ag) wcnt = (wcnt < MAXW) ? wcnt + 1 : MAXW;
      else                    wcnt = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.vga_req = 0; bus.aux_req = 0; bus.vga_urgent = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  n;
    bit  any_ag, any_rv;
    reset = 0; cyc = 0; wcnt = 0; e_forced = 0; e_addr = '0; e_we = 0; e_wdata = '0;
    bus.vga_req = 1; bus.vga_addr = 16'h0100; bus.vga_urgent = 0;
    bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
    @(negedge clk);

    // Reset held with VGA requesting, then release: grant in the same cycle.
    for (int i = 0; i < 3; i++) tick();
    reset = 1;

    // VGA-only streaming over 0x0100..0x0103.
    n = 0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      tick();
      if (last_vg) begin n++; bus.vga_addr = bus.vga_addr + 1'b1; end
    end
    check("vga_stream_cnt", n, 4);
    idle(4);

    // Aux write 0x1234 to 0x0050, then read it back.
    bus.aux_req = 1; bus.aux_we = 1; bus.aux_addr = 16'h0050; bus.aux_wdata = 16'h1234;
    tick();
    check("aux_wr_gnt", last_ag, 1);
    bus.aux_we = 0; bus.aux_wdata = 16'hDEAD;
    tick();
    bus.aux_req = 0;
    idle(4);

    // Starvation without urgency: aux is forced on the (MAXW+1)th edge.
    bus.vga_req = 1; bus.vga_addr = 16'h0300;
    bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 16'h0060;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (last_vg) bus.vga_addr = bus.vga_addr + 1'b1;
      if (last_ag) break;
    end
    check("starve_edges", n, MAXW + 1);
    check("forced_pulse", bus.aux_forced, 1);
    bus.aux_req = 0;
    tick();
    check("vga_resume", last_vg, 1);
    idle(3);

    // Urgency hold-off: aux stays denied, then wins as soon as urgent drops.
    bus.vga_req = 1; bus.vga_urgent = 1;
    bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 16'h0070;
    any_ag = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_ag |= last_ag;
      if (last_vg) bus.vga_addr = bus.vga_addr + 1'b1;
    end
    check("urgent_hold", any_ag, 0);
    bus.vga_urgent = 0;
    tick();
    check("urgent_release", last_ag, 1);
    bus.aux_req = 0;
    idle(4);

    // Mid-flight reset: a granted VGA read never returns.
    bus.vga_req = 1; bus.vga_addr = 16'h0200;
    tick();
    check("mf_vga_gnt", last_vg, 1);
    bus.vga_req = 0;
    reset = 0;
    any_rv = 0;
    for (int i = 0; i < 2; i++) begin tick(); any_rv |= bus.vga_rvalid; end
    reset = 1;
    for (int i = 0; i < 3; i++) begin tick(); any_rv |= bus.vga_rvalid; end
    check("mf_no_rvalid", any_rv, 0);

    // Randomized traffic; requests are held until granted.
    for (int i = 0; i < 400; i++) begin
      if (!(bus.vga_req && !last_vg)) begin
        bus.vga_req  = ($urandom_range(0, 99) < 60);
        bus.vga_addr = AW'($urandom_range(0, 31));
      end
      if (!(bus.aux_req && !last_ag)) begin
        bus.aux_req   = ($urandom_range(0, 99) < 45);
        bus.aux_we    = $urandom_range(0, 1);
        bus.aux_addr  = AW'($urandom_range(0, 31));
        bus.aux_wdata = DW'($urandom);
      end
      bus.vga_urgent = ($urandom_range(0, 99) < 15);
      tick();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
